// File: rtl/melody_sequencer.sv
// melody_sequencer: multi-tune square-wave melody player.
// Each tune lives in its own region of an external synchronous ROM. The
// region starts with a header word holding the note count, and the notes
// follow it. The player supports rests, looping, pause through enable and
// abort through stop.
module melody_sequencer #(
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int ADDRESS_BITS    = 8,
    parameter int TUNE_SEL_BITS   = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     start,
    input  logic                     stop,
    input  logic [TUNE_SEL_BITS-1:0] tune_select,
    input  logic                     repeat_tune,
    output logic [ADDRESS_BITS-1:0]  rom_address,
    input  logic [35:0]              rom_data,
    output logic                     sound,
    output logic                     busy,
    output logic                     done,
    output logic [7:0]               note_index
);

    localparam int REGION_BITS = ADDRESS_BITS - TUNE_SEL_BITS;
    localparam int MS_DIV      = CLOCK_FREQUENCY / 1000;
    localparam int DUR_BITS    = 48;

    // The largest note count that keeps every note address inside the region.
    localparam int              N_MAX_INT  = (REGION_BITS >= 8) ? 255 : ((1 << REGION_BITS) - 1);
    localparam logic [7:0]      N_MAX      = 8'(N_MAX_INT);
    localparam logic [DUR_BITS-1:0]     DUR_MS_DIV = DUR_BITS'(MS_DIV);
    localparam logic [DUR_BITS-1:0]     DUR_ONE    = DUR_BITS'(32'd1);
    localparam logic [ADDRESS_BITS-1:0] ADDR_ONE   = ADDRESS_BITS'(32'd1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_HDR_WAIT  = 3'd1,
        ST_HDR_LOAD  = 3'd2,
        ST_NOTE_WAIT = 3'd3,
        ST_NOTE_LOAD = 3'd4,
        ST_PLAY      = 3'd5,
        ST_NEXT      = 3'd6
    } state_t;

    state_t                  state_r, state_s;
    logic [ADDRESS_BITS-1:0] base_r, base_s;
    logic [ADDRESS_BITS-1:0] rom_address_r, rom_address_s;
    logic [7:0]              n_r, n_s;
    logic [7:0]              note_index_r, note_index_s;
    logic [DUR_BITS-1:0]     dur_target_r, dur_target_s;
    logic [DUR_BITS-1:0]     dur_cnt_r, dur_cnt_s;
    logic [19:0]             half_r, half_s;
    logic [19:0]             tone_cnt_r, tone_cnt_s;
    logic                    sound_r, sound_s;
    logic                    busy_r, busy_s;
    logic                    done_r, done_s;

    logic [ADDRESS_BITS-1:0] tune_base_s;
    logic [7:0]              hdr_count_s;
    logic [15:0]             note_dur_s;
    logic [19:0]             note_half_s;
    logic                    dur_last_s;
    logic                    tone_hit_s;
    logic                    more_notes_s;

    assign tune_base_s  = {tune_select, {REGION_BITS{1'b0}}};
    assign hdr_count_s  = (rom_data[7:0] > N_MAX) ? N_MAX : rom_data[7:0];
    assign note_dur_s   = rom_data[35:20];
    assign note_half_s  = rom_data[19:0];
    // The last PLAY cycle of a note is the one where the count reaches its target.
    assign dur_last_s   = ((dur_cnt_r + DUR_ONE) >= dur_target_r);
    assign tone_hit_s   = (half_r != 20'd0) && (tone_cnt_r == (half_r - 20'd1));
    assign more_notes_s = (({1'b0, note_index_r} + 9'd1) < {1'b0, n_r});

    assign rom_address = rom_address_r;
    assign sound       = sound_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign note_index  = note_index_r;

    // State register: reset wins, and enable low freezes the state.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else if (enable) begin
            state_r <= state_s;
        end
    end

    // Next-state logic: stop aborts from any state.
    always_comb begin
        state_s = state_r;
        if (stop) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_s = ST_HDR_WAIT;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_HDR_WAIT: state_s = ST_HDR_LOAD;
                ST_HDR_LOAD: begin
                    if (hdr_count_s == 8'd0) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_NOTE_WAIT;
                    end
                end
                ST_NOTE_WAIT: state_s = ST_NOTE_LOAD;
                ST_NOTE_LOAD: begin
                    if (note_dur_s == 16'd0) begin
                        state_s = ST_NEXT;
                    end else begin
                        state_s = ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (dur_last_s) begin
                        state_s = ST_NEXT;
                    end else begin
                        state_s = ST_PLAY;
                    end
                end
                ST_NEXT: begin
                    if (more_notes_s || repeat_tune) begin
                        state_s = ST_NOTE_WAIT;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                default: state_s = ST_IDLE;
            endcase
        end
    end

    // Output and datapath next values: sound defaults to 0 outside PLAY, and done defaults to 0 so that it lasts one cycle.
    always_comb begin
        base_s        = base_r;
        rom_address_s = rom_address_r;
        n_s           = n_r;
        note_index_s  = note_index_r;
        dur_target_s  = dur_target_r;
        dur_cnt_s     = dur_cnt_r;
        half_s        = half_r;
        tone_cnt_s    = tone_cnt_r;
        sound_s       = 1'b0;
        busy_s        = busy_r;
        done_s        = 1'b0;
        if (stop) begin
            busy_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        base_s        = tune_base_s;
                        rom_address_s = tune_base_s;
                        busy_s        = 1'b1;
                    end else begin
                        busy_s = 1'b0;
                    end
                end
                ST_HDR_WAIT: begin
                    busy_s = 1'b1;
                end
                ST_HDR_LOAD: begin
                    n_s = hdr_count_s;
                    if (hdr_count_s == 8'd0) begin
                        done_s = 1'b1;
                        busy_s = 1'b0;
                    end else begin
                        note_index_s  = 8'd0;
                        rom_address_s = base_r + ADDR_ONE;
                    end
                end
                ST_NOTE_WAIT: begin
                    busy_s = 1'b1;
                end
                ST_NOTE_LOAD: begin
                    dur_target_s = DUR_BITS'(note_dur_s) * DUR_MS_DIV;
                    half_s       = note_half_s;
                    dur_cnt_s    = {DUR_BITS{1'b0}};
                    tone_cnt_s   = 20'd0;
                end
                ST_PLAY: begin
                    if (dur_last_s) begin
                        dur_cnt_s = dur_cnt_r;
                    end else begin
                        dur_cnt_s = dur_cnt_r + DUR_ONE;
                        if (half_r == 20'd0) begin
                            tone_cnt_s = 20'd0;
                        end else if (tone_hit_s) begin
                            sound_s    = ~sound_r;
                            tone_cnt_s = 20'd0;
                        end else begin
                            sound_s    = sound_r;
                            tone_cnt_s = tone_cnt_r + 20'd1;
                        end
                    end
                end
                ST_NEXT: begin
                    if (more_notes_s) begin
                        note_index_s  = note_index_r + 8'd1;
                        rom_address_s = rom_address_r + ADDR_ONE;
                    end else if (repeat_tune) begin
                        note_index_s  = 8'd0;
                        rom_address_s = base_r + ADDR_ONE;
                    end else begin
                        done_s = 1'b1;
                        busy_s = 1'b0;
                    end
                end
                default: begin
                    busy_s = 1'b0;
                end
            endcase
        end
    end

    // Datapath and output registers: reset clears everything, and enable low holds every value.
    always_ff @(posedge clock) begin
        if (!reset) begin
            base_r        <= {ADDRESS_BITS{1'b0}};
            rom_address_r <= {ADDRESS_BITS{1'b0}};
            n_r           <= 8'd0;
            note_index_r  <= 8'd0;
            dur_target_r  <= {DUR_BITS{1'b0}};
            dur_cnt_r     <= {DUR_BITS{1'b0}};
            half_r        <= 20'd0;
            tone_cnt_r    <= 20'd0;
            sound_r       <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else if (enable) begin
            base_r        <= base_s;
            rom_address_r <= rom_address_s;
            n_r           <= n_s;
            note_index_r  <= note_index_s;
            dur_target_r  <= dur_target_s;
            dur_cnt_r     <= dur_cnt_s;
            half_r        <= half_s;
            tone_cnt_r    <= tone_cnt_s;
            sound_r       <= sound_s;
            busy_r        <= busy_s;
            done_r        <= done_s;
        end
    end

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed testbench for melody_sequencer with MS_DIV = 4.
module tb_melody_sequencer;

    logic        clock;
    logic        reset;
    logic        enable;
    logic        start;
    logic        stop;
    logic [1:0]  tune_select;
    logic        repeat_tune;
    logic [7:0]  rom_address;
    logic [35:0] rom_data;
    logic        sound;
    logic        busy;
    logic        done;
    logic [7:0]  note_index;

    logic [35:0] rom_mem [0:255];

    int check_cnt;
    int pass_cnt;
    int fail_cnt;

    melody_sequencer #(
        .CLOCK_FREQUENCY(4000),
        .ADDRESS_BITS(8),
        .TUNE_SEL_BITS(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .start(start),
        .stop(stop),
        .tune_select(tune_select),
        .repeat_tune(repeat_tune),
        .rom_address(rom_address),
        .rom_data(rom_data),
        .sound(sound),
        .busy(busy),
        .done(done),
        .note_index(note_index)
    );

    // Free-running clock with a period of 10 time units.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Synchronous ROM: data appears one edge after the address is registered.
    always_ff @(posedge clock) begin
        rom_data <= rom_mem[rom_address];
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        check_cnt++;
        assert (got === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Directed stimulus and checks.
    initial begin
        logic [7:0] tone_pat;
        logic       acc;
        logic       seen;
        int         cycles;
        logic [7:0] max_addr;
        logic [7:0] max_idx;

        check_cnt = 0;
        pass_cnt  = 0;
        fail_cnt  = 0;

        for (int i = 0; i < 256; i++) rom_mem[i] = 36'd0;
        rom_mem[64]  = 36'd2;
        rom_mem[65]  = {16'd2, 20'd2};
        rom_mem[66]  = {16'd1, 20'd0};
        rom_mem[128] = 36'd1;
        rom_mem[129] = {16'd5, 20'd3};
        rom_mem[192] = 36'd200;
        for (int i = 193; i < 256; i++) rom_mem[i] = {16'd1, 20'd1};

        reset = 1'b0; enable = 1'b1; start = 1'b0; stop = 1'b0;
        tune_select = 2'd0; repeat_tune = 1'b0;
        tick(); tick();
        check("rst_addr", 64'(rom_address), 64'd0);
        check("rst_sound", 64'(sound), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_idx", 64'(note_index), 64'd0);
        reset = 1'b1;
        tick();

        // Tune 1: a tone note followed by a rest.
        tune_select = 2'd1; start = 1'b1;
        tick(); start = 1'b0;
        check("s1_busy", 64'(busy), 64'd1);
        check("s1_base", 64'(rom_address), 64'd64);
        tick(); tick();
        check("s1_addr1", 64'(rom_address), 64'd65);
        check("s1_idx0", 64'(note_index), 64'd0);
        tick(); tick();
        check("s1_load_snd", 64'(sound), 64'd0);
        tone_pat = 8'b0110_0110;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("s1_tone", 64'(sound), 64'(tone_pat[k]));
        end
        tick();
        check("s1_idx1", 64'(note_index), 64'd1);
        check("s1_addr2", 64'(rom_address), 64'd66);
        acc = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            acc = acc | sound | done;
        end
        check("s1_gap_rest", 64'(acc), 64'd0);
        tick();
        check("s1_done", 64'(done), 64'd1);
        check("s1_busy_lo", 64'(busy), 64'd0);
        tick();
        check("s1_done_clr", 64'(done), 64'd0);

        // Tune 0: empty tune.
        tune_select = 2'd0; start = 1'b1;
        tick(); start = 1'b0;
        check("s2_busy", 64'(busy), 64'd1);
        check("s2_snd0", 64'(sound), 64'd0);
        tick();
        check("s2_nodone", 64'(done), 64'd0);
        tick();
        check("s2_done", 64'(done), 64'd1);
        check("s2_busy_lo", 64'(busy), 64'd0);
        check("s2_snd", 64'(sound), 64'd0);
        tick();
        check("s2_done_clr", 64'(done), 64'd0);

        // Tune 1 with repeat, then repeat dropped.
        tune_select = 2'd1; repeat_tune = 1'b1; start = 1'b1;
        tick(); start = 1'b0;
        for (int k = 0; k < 13; k++) tick();
        check("s3_idx1", 64'(note_index), 64'd1);
        for (int k = 0; k < 7; k++) tick();
        check("s3_wrap_idx", 64'(note_index), 64'd0);
        check("s3_wrap_addr", 64'(rom_address), 64'd65);
        check("s3_no_done", 64'(done), 64'd0);
        check("s3_busy", 64'(busy), 64'd1);
        repeat_tune = 1'b0;
        acc = 1'b0;
        for (int k = 0; k < 17; k++) begin
            tick();
            acc = acc | done;
        end
        check("s3_early_done", 64'(acc), 64'd0);
        tick();
        check("s3_done", 64'(done), 64'd1);
        check("s3_busy_lo", 64'(busy), 64'd0);

        // Stop together with start, first in IDLE and then mid-PLAY.
        tune_select = 2'd2; start = 1'b1; stop = 1'b1;
        tick();
        check("s4_idle_stop", 64'(busy), 64'd0);
        stop = 1'b0;
        tick(); start = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        check("s4_snd_hi", 64'(sound), 64'd1);
        stop = 1'b1; start = 1'b1;
        tick();
        check("s4_stop_busy", 64'(busy), 64'd0);
        check("s4_stop_snd", 64'(sound), 64'd0);
        check("s4_stop_done", 64'(done), 64'd0);
        stop = 1'b0; start = 1'b0;
        acc = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            acc = acc | done | busy;
        end
        check("s4_after", 64'(acc), 64'd0);

        // Pause for 10 cycles in the middle of a note.
        tune_select = 2'd2; start = 1'b1;
        tick(); start = 1'b0;
        for (int k = 0; k < 9; k++) tick();
        check("s5_snd_hi", 64'(sound), 64'd1);
        enable = 1'b0;
        acc = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            acc = acc | (sound !== 1'b1) | (note_index !== 8'd0) | (busy !== 1'b1) | (rom_address !== 8'd129);
        end
        check("s5_frozen", 64'(acc), 64'd0);
        enable = 1'b1;
        tick();
        check("s5_resume_tgl", 64'(sound), 64'd0);
        acc = 1'b0;
        for (int k = 0; k < 14; k++) begin
            tick();
            acc = acc | done;
        end
        check("s5_early_done", 64'(acc), 64'd0);
        tick();
        check("s5_done", 64'(done), 64'd1);

        // Tune 3: the header asks for 200 notes, but only 63 fit in the region.
        tick();
        tune_select = 2'd3; start = 1'b1;
        tick(); start = 1'b0;
        seen = 1'b0; cycles = 0; max_addr = 8'd0; max_idx = 8'd0;
        while (!seen && cycles < 600) begin
            tick();
            cycles++;
            if (rom_address > max_addr) max_addr = rom_address;
            if (note_index > max_idx) max_idx = note_index;
            if (done === 1'b1) seen = 1'b1;
        end
        check("s6_done_seen", 64'(seen), 64'd1);
        check("s6_cycles", 64'(cycles), 64'd443);
        check("s6_max_addr", 64'(max_addr), 64'd255);
        check("s6_max_idx", 64'(max_idx), 64'd62);

        // Reset in the middle of the tune, applied while enable is low.
        tick();
        start = 1'b1;
        tick(); start = 1'b0;
        for (int k = 0; k < 20; k++) tick();
        check("s6_busy_mid", 64'(busy), 64'd1);
        enable = 1'b0; reset = 1'b0;
        tick();
        check("s6_rst_addr", 64'(rom_address), 64'd0);
        check("s6_rst_busy", 64'(busy), 64'd0);
        check("s6_rst_snd", 64'(sound), 64'd0);
        check("s6_rst_idx", 64'(note_index), 64'd0);
        check("s6_rst_done", 64'(done), 64'd0);
        reset = 1'b1; enable = 1'b1;
        tick();
        check("s6_post_rst", 64'(busy), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
